// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD add/subtract sequencer: one shared digit adder, LSD first.
// Ports: clk, rst_n, in_valid/in_ready/op_sub/a/b in, out_valid/out_ready/s/cout/err out.
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                op_sub,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] s,
  output logic                cout,
  output logic                err
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_acc;
  logic [W-1:0]  r_s;
  logic [CW-1:0] r_cnt;
  logic          r_carry;
  logic          r_err_cap;
  logic          r_cout;
  logic          r_err;

  logic [W-1:0]  w_b_nine;
  logic          w_bad;
  logic [4:0]    w_t;
  logic [4:0]    w_tm;
  logic          w_c;
  logic [3:0]    w_dig;
  logic          w_last;
  logic [W-1:0]  w_sum;

  // nine's complement of b and digit-range check on both operands
  always_comb begin
    w_b_nine = '0;
    w_bad    = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      w_b_nine[4*i +: 4] = 4'd9 - b[4*i +: 4];
      if (a[4*i +: 4] > 4'd9) w_bad = 1'b1;
      if (b[4*i +: 4] > 4'd9) w_bad = 1'b1;
    end
  end

  // operands shift right each step, so the active digit is always [3:0]
  assign w_t    = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]}
                + {4'd0, r_carry};
  assign w_tm   = w_t - 5'd10;
  assign w_c    = (w_t > 5'd9);
  assign w_dig  = w_c ? w_tm[3:0] : w_t[3:0];
  assign w_last = (r_cnt == LAST);
  assign w_sum  = {w_dig, r_acc[W-1:4]};

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (in_valid) w_next = RUN;
      RUN:  if (w_last) w_next = DONE;
      DONE: if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_s       <= '0;
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_err_cap <= 1'b0;
      r_cout    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a       <= a;
            r_b       <= op_sub ? w_b_nine : b;
            r_carry   <= op_sub;
            r_cnt     <= '0;
            r_err_cap <= w_bad;
          end
        end
        RUN: begin
          r_acc   <= w_sum;
          r_a     <= r_a >> 4;
          r_b     <= r_b >> 4;
          r_carry <= w_c;
          r_cnt   <= r_cnt + 1'b1;
          // visible result only changes on entry to DONE
          if (w_last) begin
            r_s    <= r_err_cap ? '0 : w_sum;
            r_cout <= r_err_cap ? 1'b0 : w_c;
            r_err  <= r_err_cap;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign s         = r_s;
  assign cout      = r_cout;
  assign err       = r_err;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed bench for bcd_serial_add_ctrl with an expected-result queue.
// Ports driven: clk, rst_n, in_valid, op_sub, a, b, out_ready.
module tb_bcd_serial_add_ctrl;

  localparam int DIGITS = 8;
  localparam int W = 4 * DIGITS;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;
  logic         err;

  typedef struct packed {
    logic [W-1:0] s;
    logic         cout;
    logic         err;
  } exp_t;

  exp_t sbq[$];
  int   n_checks;
  int   n_errors;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_sub(op_sub), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic longint bcd2int(input logic [W-1:0] v);
    longint r = 0;
    for (int i = DIGITS - 1; i >= 0; i--)
      r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint v);
    logic [W-1:0] r = '0;
    longint x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // reference result from plain decimal arithmetic
  function automatic exp_t model(input logic [W-1:0] ma,
                                 input logic [W-1:0] mb,
                                 input logic msub);
    exp_t e;
    longint m = 1;
    longint va;
    longint vb;
    logic bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      m = m * 10;
      if (ma[4*i +: 4] > 4'd9 || mb[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    va = bcd2int(ma);
    vb = bcd2int(mb);
    e.err = bad;
    if (bad) begin
      e.s = '0;
      e.cout = 1'b0;
    end else if (!msub) begin
      e.s = int2bcd((va + vb) % m);
      e.cout = (va + vb) >= m;
    end else if (va >= vb) begin
      e.s = int2bcd(va - vb);
      e.cout = 1'b1;
    end else begin
      e.s = int2bcd(m - (vb - va));
      e.cout = 1'b0;
    end
    return e;
  endfunction

  task automatic run_op(input logic [W-1:0] ta,
                        input logic [W-1:0] tb2,
                        input logic tsub,
                        input int stall,
                        input logic pulse);
    int   lat;
    int   wr;
    exp_t g;
    wr = 0;
    @(negedge clk);
    while (!in_ready && wr < 40) begin
      @(negedge clk);
      wr++;
    end
    check("ready_before_op", 64'(in_ready), 64'd1);
    a = ta;
    b = tb2;
    op_sub = tsub;
    in_valid = 1'b1;
    out_ready = 1'b0;
    sbq.push_back(model(ta, tb2, tsub));
    @(posedge clk);
    #1;
    in_valid = pulse;
    if (pulse) begin
      a = 32'h1111_1111;
      b = 32'h2222_2222;
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(DIGITS));
    if (sbq.size() == 0) begin
      check("queue_nonempty", 64'd0, 64'd1);
      return;
    end
    g = sbq.pop_front();
    check("s", 64'(s), 64'(g.s));
    check("cout", 64'(cout), 64'(g.cout));
    check("err", 64'(err), 64'(g.err));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_busy", 64'(in_ready), 64'd0);
      check("stall_s", 64'(s), 64'(g.s));
      check("stall_cout", 64'(cout), 64'(g.cout));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("hs_valid_low", 64'(out_valid), 64'd0);
    check("hs_ready_high", 64'(in_ready), 64'd1);
    check("hs_s_kept", 64'(s), 64'(g.s));
  endtask

  initial begin
    int seen;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op_sub = 1'b0;
    a = '0;
    b = '0;
    #23;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_s", 64'(s), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'h1234_5678, 32'h8765_4321, 1'b0, 0, 1'b0);
    run_op(32'h9999_9999, 32'h0000_0001, 1'b0, 0, 1'b0);
    run_op(32'h0000_0100, 32'h0000_0001, 1'b1, 0, 1'b0);
    run_op(32'h0000_0001, 32'h0000_0002, 1'b1, 0, 1'b0);
    run_op(32'h0482_9175, 32'h0317_6649, 1'b0, 5, 1'b1);
    run_op(32'h0000_000A, 32'h0000_0001, 1'b0, 0, 1'b0);
    run_op(32'h5000_0000, 32'h4999_9999, 1'b1, 2, 1'b0);
    run_op(32'h0000_0000, 32'h0000_0000, 1'b1, 0, 1'b0);

    // abort an operation mid-run with an asynchronous reset
    @(negedge clk);
    a = 32'h1111_1111;
    b = 32'h2222_2222;
    op_sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("abort_running", 64'(in_ready), 64'd0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("abort_no_result", 64'(seen), 64'd0);

    run_op(32'h0000_0999, 32'h0000_0001, 1'b0, 0, 1'b0);
    check("queue_empty", 64'(sbq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
